// File: rtl/countdown_ctrl.sv
// ============================================================================
// Module   : countdown_ctrl
// Desc     : HH:MM:SS countdown sequencer (SET/RUN/PAUSE/DONE) feeding the
//            display mux with packed BCD values. Optional DONE auto-clear
//            built when COUNTDOWN_AUTOCLEAR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_ctrl #(
    parameter int unsigned DONE_SECS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        btn_sel,
    input  logic        btn_inc,
    input  logic        btn_start,
    output logic [31:0] tmp1,
    output logic [31:0] tmp,
    output logic [3:0]  state,
    output logic        go,
    output logic        finish
);

    localparam logic [1:0] c_ST_SET   = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_PAUSE = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [3:0] c_SEP = 4'hb;
    // Digit index 0 = sec ones ... 5 = hr tens; wrap/borrow limit per digit.
    localparam logic [5:0][3:0] c_DIGIT_MAX = {4'd9, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9};

    logic [1:0]       r_fsm, w_fsm_nxt;
    logic [5:0][3:0]  r_set, w_set_nxt;
    logic [5:0][3:0]  r_run, w_run_nxt;
    logic [2:0]       r_sel, w_sel_nxt;
    logic [5:0][3:0]  w_dec;
    logic             w_dec_zero;
    logic [3:0]       w_inc_digit;
    logic             w_auto_clear;

    // One-second BCD decrement with a ripple borrow across all six digits.
    always_comb begin
        logic v_borrow;
        w_dec    = r_run;
        v_borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (v_borrow) begin
                if (r_run[i] == 4'd0) begin
                    w_dec[i] = c_DIGIT_MAX[i];
                end else begin
                    w_dec[i] = r_run[i] - 4'd1;
                    v_borrow = 1'b0;
                end
            end
        end
        w_dec_zero = (w_dec == '0);
    end

    assign w_inc_digit = (r_set[r_sel] >= c_DIGIT_MAX[r_sel]) ? 4'd0 : r_set[r_sel] + 4'd1;

`ifdef COUNTDOWN_AUTOCLEAR_EN
    localparam int unsigned c_CNT_W = (DONE_SECS < 2) ? 1 : $clog2(DONE_SECS + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DONE_SECS - 1);

    logic [c_CNT_W-1:0] r_done_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_cnt <= '0;
        end else if (r_fsm != c_ST_DONE || btn_start || btn_sel) begin
            r_done_cnt <= '0;
        end else if (tick) begin
            r_done_cnt <= r_done_cnt + 1'b1;
        end
    end

    assign w_auto_clear = tick && (r_done_cnt == c_CNT_LAST);
`else
    assign w_auto_clear = 1'b0;
`endif

    // State and data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= c_ST_SET;
            r_set <= '0;
            r_run <= '0;
            r_sel <= 3'd0;
        end else begin
            r_fsm <= w_fsm_nxt;
            r_set <= w_set_nxt;
            r_run <= w_run_nxt;
            r_sel <= w_sel_nxt;
        end
    end

    // Next-state logic; start outranks sel outranks inc in every state.
    always_comb begin
        w_fsm_nxt = r_fsm;
        w_set_nxt = r_set;
        w_run_nxt = r_run;
        w_sel_nxt = r_sel;
        case (r_fsm)
            c_ST_SET: begin
                if (btn_start) begin
                    if (r_set != '0) begin
                        w_run_nxt = r_set;
                        w_fsm_nxt = c_ST_RUN;
                    end
                end else if (btn_sel) begin
                    w_sel_nxt = (r_sel == 3'd5) ? 3'd0 : r_sel + 3'd1;
                end else if (btn_inc) begin
                    w_set_nxt[r_sel] = w_inc_digit;
                end
            end
            c_ST_RUN: begin
                if (btn_start) begin
                    w_fsm_nxt = c_ST_PAUSE;
                end else if (tick) begin
                    w_run_nxt = w_dec;
                    if (w_dec_zero) begin
                        w_fsm_nxt = c_ST_DONE;
                    end
                end
            end
            c_ST_PAUSE: begin
                if (btn_start) begin
                    w_fsm_nxt = c_ST_RUN;
                end else if (btn_sel) begin
                    w_fsm_nxt = c_ST_SET;
                end
            end
            c_ST_DONE: begin
                if (btn_start || btn_sel || w_auto_clear) begin
                    w_fsm_nxt = c_ST_SET;
                end
            end
            default: w_fsm_nxt = c_ST_SET;
        endcase
    end

    // Outputs decoded purely from registers
    always_comb begin
        tmp1   = {r_set[5], r_set[4], c_SEP, r_set[3], r_set[2], c_SEP, r_set[1], r_set[0]};
        tmp    = {r_run[5], r_run[4], c_SEP, r_run[3], r_run[2], c_SEP, r_run[1], r_run[0]};
        state  = {1'b0, r_sel} + 4'd1;
        go     = (r_fsm == c_ST_RUN) || (r_fsm == c_ST_PAUSE);
        finish = (r_fsm == c_ST_DONE);
    end

endmodule

`default_nettype wire

// File: tb/tb_countdown_ctrl.sv
// ============================================================================
// Module   : tb_countdown_ctrl
// Desc     : Directed scoreboard bench for countdown_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_countdown_ctrl;

    localparam logic [31:0] c_R = 32'h00b00b00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        btn_sel = 1'b0;
    logic        btn_inc = 1'b0;
    logic        btn_start = 1'b0;
    logic [31:0] tmp1, tmp;
    logic [3:0]  state;
    logic        go, finish;

    countdown_ctrl #(.DONE_SECS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .btn_sel   (btn_sel),
        .btn_inc   (btn_inc),
        .btn_start (btn_start),
        .tmp1      (tmp1),
        .tmp       (tmp),
        .state     (state),
        .go        (go),
        .finish    (finish)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] t1;
        logic [31:0] t;
        logic [3:0]  st;
        logic        g;
        logic        f;
    } exp_t;

    exp_t        sb[$];
    exp_t        m_e;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] e_t1, e_t;
    logic [3:0]  e_st;
    logic        e_go, e_fin;

    task automatic ex(input logic [31:0] t1, input logic [31:0] t, input int st,
                      input logic g, input logic f);
        e_t1 = t1; e_t = t; e_st = 4'(st); e_go = g; e_fin = f;
    endtask

    // Drive one input cycle and queue the response expected after its edge.
    task automatic cyc(input string nm, input logic r, input logic tk, input logic s,
                       input logic i, input logic b);
        @(negedge clk);
        rst = r; tick = tk; btn_sel = s; btn_inc = i; btn_start = b;
        sb.push_back('{nm, e_t1, e_t, e_st, e_go, e_fin});
    endtask

    always begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            m_e = sb.pop_front();
            checks++;
            if (tmp1 !== m_e.t1 || tmp !== m_e.t || state !== m_e.st ||
                go !== m_e.g || finish !== m_e.f) begin
                errors++;
                $display("FAIL %s: got tmp1=%h tmp=%h state=%0d go=%b finish=%b, expected tmp1=%h tmp=%h state=%0d go=%b finish=%b",
                         m_e.nm, tmp1, tmp, state, go, finish, m_e.t1, m_e.t, m_e.st, m_e.g, m_e.f);
            end
        end
    end

    initial begin
        ex(c_R, c_R, 1, 0, 0);            cyc("reset", 1, 0, 0, 0, 0);
        ex(c_R, c_R, 2, 0, 0);            cyc("sel1", 0, 0, 1, 0, 0);
        ex(c_R, c_R, 3, 0, 0);            cyc("sel2", 0, 0, 1, 0, 0);
        ex(c_R, c_R, 4, 0, 0);            cyc("sel3", 0, 0, 1, 0, 0);
        ex(32'h00b10b00, c_R, 4, 0, 0);   cyc("inc_mt1", 0, 0, 0, 1, 0);
        ex(32'h00b20b00, c_R, 4, 0, 0);   cyc("inc_mt2", 0, 0, 0, 1, 0);

        ex(c_R, c_R, 1, 0, 0);            cyc("reset2", 1, 0, 0, 0, 0);
        ex(c_R, c_R, 1, 0, 0);            cyc("start_zero", 0, 0, 0, 0, 1);
        ex(c_R, c_R, 1, 0, 0);            cyc("set_tick", 0, 1, 0, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            ex(c_R, c_R, (k % 6) + 1, 0, 0); cyc("sel_wrap", 0, 0, 1, 0, 0);
        end

        // Second tens wrap 5 -> 0
        ex(c_R, c_R, 2, 0, 0);            cyc("sel_st", 0, 0, 1, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            ex({24'h00b00b, 4'(k % 6), 4'h0}, c_R, 2, 0, 0);
            cyc("inc_st_wrap", 0, 0, 0, 1, 0);
        end

        // 01:00:00 -> run
        ex(c_R, c_R, 3, 0, 0);            cyc("sel_to3", 0, 0, 1, 0, 0);
        ex(c_R, c_R, 4, 0, 0);            cyc("sel_to4", 0, 0, 1, 0, 0);
        ex(c_R, c_R, 5, 0, 0);            cyc("sel_to5", 0, 0, 1, 0, 0);
        ex(32'h01b00b00, c_R, 5, 0, 0);   cyc("inc_ho", 0, 0, 0, 1, 0);
        ex(32'h01b00b00, 32'h01b00b00, 5, 1, 0); cyc("start_tick", 0, 1, 0, 0, 1);
        ex(32'h01b00b00, 32'h00b59b59, 5, 1, 0); cyc("tick_borrow", 0, 1, 0, 0, 0);
        ex(32'h01b00b00, 32'h00b59b58, 5, 1, 0); cyc("tick2", 0, 1, 0, 0, 0);
        ex(32'h01b00b00, 32'h00b59b58, 5, 1, 0); cyc("pause_tick", 0, 1, 0, 0, 1);
        ex(32'h01b00b00, 32'h00b59b58, 5, 1, 0); cyc("paused_tick", 0, 1, 0, 0, 0);
        ex(32'h01b00b00, 32'h00b59b58, 5, 1, 0); cyc("paused_inc", 0, 0, 0, 1, 0);
        ex(32'h01b00b00, 32'h00b59b58, 5, 1, 0); cyc("resume", 0, 0, 0, 0, 1);
        ex(32'h01b00b00, 32'h00b59b57, 5, 1, 0); cyc("tick3", 0, 1, 0, 0, 0);
        ex(32'h01b00b00, 32'h00b59b57, 5, 1, 0); cyc("pause2", 0, 0, 0, 0, 1);
        ex(32'h01b00b00, 32'h00b59b57, 5, 0, 0); cyc("abort", 0, 0, 1, 0, 0);
        ex(32'h01b00b00, 32'h01b00b00, 5, 1, 0); cyc("restart", 0, 0, 0, 0, 1);
        ex(c_R, c_R, 1, 0, 0);            cyc("reset_run", 1, 1, 0, 0, 0);

        // Count down from 00:00:02 to DONE
        ex(32'h00b00b01, c_R, 1, 0, 0);   cyc("inc_so1", 0, 0, 0, 1, 0);
        ex(32'h00b00b02, c_R, 1, 0, 0);   cyc("inc_so2", 0, 0, 0, 1, 0);
        ex(32'h00b00b02, 32'h00b00b02, 1, 1, 0); cyc("start2", 0, 0, 0, 0, 1);
        ex(32'h00b00b02, 32'h00b00b01, 1, 1, 0); cyc("tick_to1", 0, 1, 0, 0, 0);
        ex(32'h00b00b02, 32'h00b00b00, 1, 0, 1); cyc("tick_done", 0, 1, 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
`ifdef COUNTDOWN_AUTOCLEAR_EN
            ex(32'h00b00b02, 32'h00b00b00, 1, 0, (k < 3));
`else
            ex(32'h00b00b02, 32'h00b00b00, 1, 0, 1);
`endif
            cyc("done_tick", 0, 1, 0, 0, 0);
        end
`ifndef COUNTDOWN_AUTOCLEAR_EN
        ex(32'h00b00b02, 32'h00b00b00, 1, 0, 1); cyc("done_inc", 0, 0, 0, 1, 0);
        ex(32'h00b00b02, 32'h00b00b00, 1, 0, 0); cyc("done_start", 0, 0, 0, 0, 1);
`endif

        // Coincident buttons: start wins, sel/inc dropped
        ex(32'h00b00b02, 32'h00b00b02, 1, 1, 0); cyc("prio_all", 0, 0, 1, 1, 1);
        ex(32'h00b00b02, 32'h00b00b02, 1, 1, 0); cyc("run_sel", 0, 0, 1, 0, 0);
        ex(32'h00b00b02, 32'h00b00b02, 1, 1, 0); cyc("run_inc", 0, 0, 0, 1, 0);
        ex(32'h00b00b02, 32'h00b00b01, 1, 1, 0); cyc("tick_a", 0, 1, 0, 0, 0);
        ex(32'h00b00b02, 32'h00b00b00, 1, 0, 1); cyc("tick_b", 0, 1, 0, 0, 0);
        ex(32'h00b00b02, 32'h00b00b00, 1, 0, 0); cyc("done_sel", 0, 0, 1, 0, 0);

        // 10:00:00 full borrow chain
        ex(c_R, c_R, 1, 0, 0);            cyc("reset3", 1, 0, 0, 0, 0);
        for (int k = 2; k <= 6; k++) begin
            ex(c_R, c_R, k, 0, 0);        cyc("sel_to_ht", 0, 0, 1, 0, 0);
        end
        ex(32'h10b00b00, c_R, 6, 0, 0);   cyc("inc_ht", 0, 0, 0, 1, 0);
        ex(32'h10b00b00, 32'h10b00b00, 6, 1, 0); cyc("start3", 0, 0, 0, 0, 1);
        ex(32'h10b00b00, 32'h09b59b59, 6, 1, 0); cyc("tick_hr_borrow", 0, 1, 0, 0, 0);
        ex(32'h10b00b00, 32'h09b59b59, 6, 1, 0); cyc("idle", 0, 0, 0, 0, 0);

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected responses left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
